// File: rtl/cardinal_pkg.sv
// cardinal_pkg
// Shared definitions for the cardinal input buffer: packet field positions,
// the default packet width, the virtual-channel slot state encoding and the
// hop-count decrement helper.
package cardinal_pkg;

    localparam int DATA_W_DEF = 64;

    // Packet field positions
    localparam int VC_BIT  = 63;  // virtual-channel tag, carried but never decoded
    localparam int DIR_BIT = 62;  // direction bit, carried unmodified
    localparam int HOP_MSB = 55;
    localparam int HOP_LSB = 48;
    localparam int HOP_W   = HOP_MSB - HOP_LSB + 1;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

    // Hop count decrement that sticks at zero instead of wrapping.
    function automatic logic [HOP_W-1:0] hop_dec(input logic [HOP_W-1:0] hop);
        return (hop == '0) ? '0 : hop - HOP_W'(1);
    endfunction

endpackage

// File: rtl/cardinal_vc_slot.sv
// cardinal_vc_slot
// One-entry virtual-channel slot: EMPTY or FULL plus one packet register.
// Ports:
//   clk, reset        - clock, asynchronous active-high reset
//   wr_en, wr_data    - capture wr_data and go FULL
//   rd_en             - release the packet and go EMPTY
//   full, data        - current occupancy and stored packet
module cardinal_vc_slot
    import cardinal_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic              full,
    output logic [DATA_W-1:0] data
);

    slot_state_e       state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d;

    // The top never writes and reads the same slot on one edge; write wins
    // here only so the slot is well defined in isolation.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no latch is inferred.
        state_d = state_q;
        data_d  = data_q;
        if (wr_en) begin
            state_d = SLOT_FULL;
            data_d  = wr_data;
        end else if (rd_en) begin
            state_d = SLOT_EMPTY;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= SLOT_EMPTY;
            // NOTE: the packet register is cleared on reset too, so a discarded packet leaves no trace.
            data_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    assign full = (state_q == SLOT_FULL);
    assign data = data_q;

endmodule

// File: rtl/cardinal_input_buffer.sv
// cardinal_input_buffer
// Router input buffer with two one-entry virtual-channel slots (VC0 even,
// VC1 odd). The network-wide polarity picks the slot written from upstream
// and the slot presented to the crossbar; they are always different, so a
// write and a read on the same edge never collide.
// Optional feature: define CARDINAL_HOPDEC_EN to decrement the hop field
// (saturating at zero) as a packet is captured.
// Ports:
//   clk, reset               - clock, asynchronous active-high reset
//   in_si, in_ri, in_di      - upstream strobe, ready, packet
//   out_so, out_ro, out_do   - crossbar valid, ready, packet (zero when idle)
//   polarity                 - 0: write VC0 / read VC1, 1: write VC1 / read VC0
//   stall_cnt                - saturating count of refused upstream strobes
module cardinal_input_buffer
    import cardinal_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_si,
    output logic              in_ri,
    input  logic [DATA_W-1:0] in_di,
    output logic              out_so,
    input  logic              out_ro,
    output logic [DATA_W-1:0] out_do,
    input  logic              polarity,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic              slot_full [2];
    logic [DATA_W-1:0] slot_data [2];
    logic [1:0]        slot_wr_en, slot_rd_en;
    logic [DATA_W-1:0] cap_data;
    logic              wr_vc, rd_vc;
    logic [CNT_W-1:0]  stall_q, stall_d;

    // Slot selection depends only on polarity, never on the packet's VC tag.
    assign wr_vc = polarity;
    assign rd_vc = ~polarity;

    assign in_ri  = ~slot_full[wr_vc];
    assign out_so = slot_full[rd_vc];
    assign out_do = out_so ? slot_data[rd_vc] : '0;

    always_comb begin
        slot_wr_en        = '0;
        slot_rd_en        = '0;
        slot_wr_en[wr_vc] = in_si & in_ri;
        slot_rd_en[rd_vc] = out_so & out_ro;
    end

    always_comb begin
        cap_data = in_di;
`ifdef CARDINAL_HOPDEC_EN
        cap_data[HOP_MSB:HOP_LSB] = hop_dec(in_di[HOP_MSB:HOP_LSB]);
`endif
    end

    // Count refused strobes, holding at all-ones.
    always_comb begin
        stall_d = stall_q;
        if (in_si && !in_ri && (stall_q != '1)) begin
            stall_d = stall_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt = stall_q;

    cardinal_vc_slot #(.DATA_W(DATA_W)) u_vc0 (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (slot_wr_en[0]),
        .wr_data (cap_data),
        .rd_en   (slot_rd_en[0]),
        .full    (slot_full[0]),
        .data    (slot_data[0])
    );

    cardinal_vc_slot #(.DATA_W(DATA_W)) u_vc1 (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (slot_wr_en[1]),
        .wr_data (cap_data),
        .rd_en   (slot_rd_en[1]),
        .full    (slot_full[1]),
        .data    (slot_data[1])
    );

endmodule

// File: tb/tb_cardinal_input_buffer.sv
// tb_cardinal_input_buffer
// Self-checking bench for cardinal_input_buffer: directed scenarios plus a
// randomized run against a two-slot behavioural model. The stall counter is
// built narrow so its saturation point is reachable in a few cycles.
module tb_cardinal_input_buffer;

    localparam int DW       = 64;
    localparam int TB_CNT_W = 4;
    localparam int CNT_MAX  = (1 << TB_CNT_W) - 1;

    logic                clk = 1'b0;
    logic                reset = 1'b0;
    logic                in_si = 1'b0;
    logic                in_ri;
    logic [DW-1:0]       in_di = '0;
    logic                out_so;
    logic                out_ro = 1'b0;
    logic [DW-1:0]       out_do;
    logic                polarity = 1'b0;
    logic [TB_CNT_W-1:0] stall_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model: two slots indexed by VC number.
    bit            m_full [2];
    logic [DW-1:0] m_data [2];
    int            m_stall;

    cardinal_input_buffer #(.DATA_W(DW), .CNT_W(TB_CNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_si     (in_si),
        .in_ri     (in_ri),
        .in_di     (in_di),
        .out_so    (out_so),
        .out_ro    (out_ro),
        .out_do    (out_do),
        .polarity  (polarity),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish, got no end expected end");
        $fatal(1, "timeout");
    end

    // Expected stored value of a captured packet.
    function automatic logic [DW-1:0] stored(input logic [DW-1:0] d);
        logic [DW-1:0] r;
        r = d;
`ifdef CARDINAL_HOPDEC_EN
        if (d[55:48] != 8'd0) r[55:48] = d[55:48] - 8'd1;
`endif
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_si  = 1'b0;
        out_ro = 1'b0;
        reset  = 1'b1;
        #1;
        reset  = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        reset = 1'b1;
        #1;
        n_tests++; if (out_so !== 1'b0) begin n_fail++; $display("FAIL reset_out_so: got %b expected 0", out_so); end
        n_tests++; if (out_do !== '0) begin n_fail++; $display("FAIL reset_out_do: got %h expected 0", out_do); end
        n_tests++; if (in_ri !== 1'b1) begin n_fail++; $display("FAIL reset_in_ri: got %b expected 1", in_ri); end
        n_tests++; if (stall_cnt !== '0) begin n_fail++; $display("FAIL reset_stall_cnt: got %0d expected 0", stall_cnt); end
        #1;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_pass_through();
        do_reset();
        polarity = 1'b0; in_si = 1'b1; in_di = 64'd1234; out_ro = 1'b0;
        #1;
        n_tests++; if (in_ri !== 1'b1) begin n_fail++; $display("FAIL pass_in_ri: got %b expected 1", in_ri); end
        tick();
        polarity = 1'b1; in_si = 1'b0; out_ro = 1'b1;
        #1;
        n_tests++; if (out_so !== 1'b1) begin n_fail++; $display("FAIL pass_out_so: got %b expected 1", out_so); end
        n_tests++; if (out_do !== 64'd1234) begin n_fail++; $display("FAIL pass_out_do: got %0d expected 1234", out_do); end
        tick();
        n_tests++; if (out_so !== 1'b0) begin n_fail++; $display("FAIL pass_drained_out_so: got %b expected 0", out_so); end
        polarity = 1'b0;
        #1;
        n_tests++; if (in_ri !== 1'b1) begin n_fail++; $display("FAIL pass_drained_in_ri: got %b expected 1", in_ri); end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] a, b;
        a = 64'h0000_0000_0000_aaaa;
        b = 64'h0000_0000_0000_bbbb;
        do_reset();
        out_ro = 1'b0; in_si = 1'b1;
        polarity = 1'b0; in_di = a; tick();
        polarity = 1'b1; in_di = b; tick();
        for (int i = 0; i < 3; i++) begin
            polarity = i[0];
            in_di = 64'hdead_0000_0000_beef;
            #1;
            n_tests++; if (in_ri !== 1'b0) begin n_fail++; $display("FAIL bp_in_ri_%0d: got %b expected 0", i, in_ri); end
            tick();
        end
        in_si = 1'b0;
        n_tests++; if (stall_cnt !== 4'd3) begin n_fail++; $display("FAIL bp_stall_cnt: got %0d expected 3", stall_cnt); end
        polarity = 1'b0;
        #1;
        n_tests++; if (out_do !== b) begin n_fail++; $display("FAIL bp_vc1_data: got %h expected %h", out_do, b); end
        polarity = 1'b1;
        #1;
        n_tests++; if (out_do !== a) begin n_fail++; $display("FAIL bp_vc0_data: got %h expected %h", out_do, a); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        polarity = 1'b1; in_si = 1'b1; in_di = 64'd5555; out_ro = 1'b0;
        tick();
        polarity = 1'b0; in_si = 1'b1; in_di = 64'd1111; out_ro = 1'b1;
        #1;
        n_tests++; if (out_do !== 64'd5555) begin n_fail++; $display("FAIL sim_out_do: got %0d expected 5555", out_do); end
        n_tests++; if (in_ri !== 1'b1) begin n_fail++; $display("FAIL sim_in_ri: got %b expected 1", in_ri); end
        tick();
        in_si = 1'b0; out_ro = 1'b0;
        #1;
        n_tests++; if (out_so !== 1'b0) begin n_fail++; $display("FAIL sim_vc1_empty: got %b expected 0", out_so); end
        polarity = 1'b1;
        #1;
        n_tests++; if (out_do !== 64'd1111) begin n_fail++; $display("FAIL sim_vc0_data: got %0d expected 1111", out_do); end
    endtask

    task automatic test_reset_mid_op();
        do_reset();
        polarity = 1'b0; in_si = 1'b1; in_di = 64'd77;
        tick();
        in_si = 1'b0;
        reset = 1'b1;
        #1;
        reset = 1'b0;
        out_ro = 1'b1;
        for (int i = 0; i < 4; i++) begin
            polarity = i[0];
            #1;
            n_tests++; if (out_so !== 1'b0 || out_do !== '0) begin n_fail++; $display("FAIL midrst_out_%0d: got so=%b do=%h expected so=0 do=0", i, out_so, out_do); end
            tick();
        end
    endtask

    task automatic test_hop_field();
        logic [DW-1:0] p3, p0, e3;
        p3 = 64'h8003_0000_0000_0042;
        p0 = 64'h4000_0000_0000_0099;
`ifdef CARDINAL_HOPDEC_EN
        e3 = 64'h8002_0000_0000_0042;
`else
        e3 = p3;
`endif
        do_reset();
        // VC tag set but written under polarity 0: must land in VC0.
        polarity = 1'b0; in_si = 1'b1; in_di = p3; tick();
        polarity = 1'b1; in_di = p0; tick();
        in_si = 1'b0;
        #1;
        n_tests++; if (out_do !== e3) begin n_fail++; $display("FAIL hop3: got %h expected %h", out_do, e3); end
        polarity = 1'b0;
        #1;
        n_tests++; if (out_do !== p0) begin n_fail++; $display("FAIL hop0: got %h expected %h", out_do, p0); end
    endtask

    task automatic test_stall_saturation();
        do_reset();
        in_si = 1'b1;
        polarity = 1'b0; tick();
        polarity = 1'b1; tick();
        for (int i = 1; i <= 20; i++) begin
            polarity = ~polarity;
            tick();
            if (i == 14 || i == 15 || i == 20) begin
                n_tests++;
                if (stall_cnt !== TB_CNT_W'((i > CNT_MAX) ? CNT_MAX : i)) begin
                    n_fail++;
                    $display("FAIL stall_sat_%0d: got %0d expected %0d", i, stall_cnt, (i > CNT_MAX) ? CNT_MAX : i);
                end
            end
        end
        in_si = 1'b0;
    endtask

    task automatic test_random();
        int            wt, rt;
        bit            acc, rd;
        logic [DW-1:0] exp_do;
        do_reset();
        m_full[0] = 0; m_full[1] = 0; m_data[0] = '0; m_data[1] = '0; m_stall = 0;
        for (int i = 0; i < 400; i++) begin
            polarity = 1'($urandom_range(0, 1));
            in_si    = ($urandom_range(0, 3) != 0);
            out_ro   = 1'($urandom_range(0, 1));
            in_di    = {$urandom, $urandom};
            #1;
            wt = int'(polarity);
            rt = 1 - wt;
            exp_do = m_full[rt] ? m_data[rt] : '0;
            n_tests++; if (in_ri !== !m_full[wt]) begin n_fail++; $display("FAIL rnd_in_ri_%0d: got %b expected %b", i, in_ri, !m_full[wt]); end
            n_tests++; if (out_so !== m_full[rt]) begin n_fail++; $display("FAIL rnd_out_so_%0d: got %b expected %b", i, out_so, m_full[rt]); end
            n_tests++; if (out_do !== exp_do) begin n_fail++; $display("FAIL rnd_out_do_%0d: got %h expected %h", i, out_do, exp_do); end
            n_tests++; if (stall_cnt !== TB_CNT_W'(m_stall)) begin n_fail++; $display("FAIL rnd_stall_%0d: got %0d expected %0d", i, stall_cnt, m_stall); end
            if ($urandom_range(0, 49) == 0) begin
                reset = 1'b1;
                #1;
                reset = 1'b0;
                in_si = 1'b0; out_ro = 1'b0;
                m_full[0] = 0; m_full[1] = 0; m_data[0] = '0; m_data[1] = '0; m_stall = 0;
                tick();
            end else begin
                acc = in_si && !m_full[wt];
                rd  = m_full[rt] && out_ro;
                if (in_si && m_full[wt] && m_stall < CNT_MAX) m_stall++;
                if (acc) begin m_full[wt] = 1; m_data[wt] = stored(in_di); end
                if (rd) m_full[rt] = 0;
                tick();
            end
        end
    endtask

    initial begin
        test_reset();
        test_pass_through();
        test_backpressure();
        test_simultaneous();
        test_reset_mid_op();
        test_hop_field();
        test_stall_saturation();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
